alu_seq: RTL
============

# alu_seq

Parametrised, handshaked successor to the single-cycle datapath ALU. Performs arithmetic, logic, shift, clamp and random-number operations at configurable width, with a valid/ready interface on both sides and registered results. It adds an optional iterative multiplier and a free-running, seedable Galois LFSR. It sits between the decode stage and the register-file write-back of the Rose Simple Computer.

## Interface
- WIDTH, 16, datapath width; power of two, ≥ 4
- LFSR_TAPS, 16'hB400, Galois feedback mask, WIDTH bits
- LFSR_SEED, 1, nonzero LFSR reset/default seed
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept request this cycle
- op  in  4  operation code
- a, b, imm  in  WIDTH each  operands
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  registered result
- zero  out  1  result == 0
- carry  out  1  carry/borrow/overflow flag (op-specific)

Reset and clock are fixed: one clock `clk`; `rst` is synchronous, active-high.

## Operation
- Accept occurs on a rising edge with in_valid && in_ready; op/a/b/imm are sampled at that edge.
- Ops:
  - 0 ADD: a+b; carry = carry-out.
  - 1 SUB: a-b; carry = borrow (a<b unsigned).
  - 2 AND, 3 OR, 4 XOR: carry=0.
  - 5 CLAMP: unsigned min(a,b); carry = (a>b).
  - 6 ADDI: a+imm; carry = carry-out.
  - 7 RNG: result = LFSR state at the accept edge.
  - 8 SEED: LFSR ← a, or LFSR_SEED if a==0; result = loaded value.
  - 9 SHL, 10 SHR (logical), 11 SRA: shift a by b[log2(WIDTH)-1:0]; carry = last bit shifted out, 0 if the shift amount is 0.
  - 12 MUL: see Configuration.
  - 13–15 illegal: result 0, zero=1, carry=0.
- Overflow wraps modulo 2^WIDTH.
- zero is always derived from the registered result.
- LFSR is free-running and advances every non-reset cycle: lsb ? (s>>1)^LFSR_TAPS : s>>1.
  - On a SEED accept, the load replaces the advance for that cycle.
  - LFSR state never becomes 0.
- State machine:
  - IDLE: in_ready=1. Accepting a single-cycle op → OUT. Accepting MUL → BUSY.
  - BUSY: in_ready=0. Shift-add one bit per cycle, WIDTH cycles → OUT.
  - OUT: out_valid=1.
    - out_ready=0: hold result/flags stable; in_ready=0.
    - out_ready=1: in_ready=1, allowing a back-to-back accept. New accept goes to OUT (single-cycle op) or BUSY (MUL); no accept → IDLE.

## Timing
- Reset values: out_valid=0, result=0, zero=0, carry=0, state IDLE, LFSR=LFSR_SEED. in_ready is forced 0 while rst=1.
- Single-cycle ops: out_valid rises 1 cycle after accept. Throughput is 1 op/cycle while out_ready=1.
- MUL: out_valid rises WIDTH+1 cycles after accept (17 at WIDTH=16).
- rst asserted during BUSY or OUT: operation is discarded; out_valid=0 on the next edge; nothing is emitted.
- in_valid while in_ready=0 is ignored. The requester holds its request.
- result, zero and carry change only on an accept's completion. They are stable while out_valid && !out_ready.

## Configuration
- `ALU_MUL_EN` defined: op 12 is an iterative shift-add multiply.
  - result = low WIDTH bits of a*b.
  - carry = 1 if the high WIDTH bits are nonzero.
  - Latency is WIDTH+1.
- `ALU_MUL_EN` undefined: no multiplier logic. Op 12 is treated as illegal: 1-cycle latency, result 0, zero=1, carry=0.

## Test plan
- Reset, then ADD a=16'hFFFF b=1 → one cycle later out_valid=1, result=0, zero=1, carry=1. SUB a=5 b=7 → result 16'hFFFE, carry=1.
- CLAMP a=300 b=255 → result 255, carry=1. SHR a=16'h8001 b=1 → result 16'h4000, carry=1. SRA a=16'h8000 b=4 → result 16'hF800.
- With ALU_MUL_EN: MUL 300×200 → result 16'hEA60, carry=0, out_valid exactly 17 cycles after accept. MUL 16'h0100×16'h0100 → result 0, carry=1. Without the macro: MUL → result 0, zero=1, 1-cycle latency.
- Backpressure: hold out_ready=0 for 3 cycles after ADD 2+3 → result stays 5, in_ready=0. Raise out_ready with a new XOR pending → accepted back-to-back.
- LFSR: SEED a=0 → result 1. The next-cycle RNG returns 16'hB400, the following cycle 16'h5A00, matching the Galois reference model.
- Assert rst during cycle 5 of a MUL → out_valid=0 and no result emitted. in_ready=1 on the first cycle after rst deasserts.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: handshaked, parametrised ALU with registered result/flags, a
// free-running seedable Galois LFSR and an optional iterative multiplier.
// Optional feature macro: ALU_MUL_EN (op 12 becomes a WIDTH-cycle shift-add
// multiply; when undefined op 12 behaves as an illegal opcode).
module alu_seq #(
    parameter int unsigned      WIDTH     = 16,
    parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(16'hB400),
    parameter logic [WIDTH-1:0] LFSR_SEED = WIDTH'(16'h0001)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry
);

    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_CLAMP = 4'd5;
    localparam logic [3:0] OP_ADDI  = 4'd6;
    localparam logic [3:0] OP_RNG   = 4'd7;
    localparam logic [3:0] OP_SEED  = 4'd8;
    localparam logic [3:0] OP_SHL   = 4'd9;
    localparam logic [3:0] OP_SHR   = 4'd10;
    localparam logic [3:0] OP_SRA   = 4'd11;
    localparam logic [3:0] OP_MUL   = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_n_s;
    logic               in_ready_s;
    logic               accept_s;
    logic               is_mul_s;
    logic               mul_done_s;
    logic [WIDTH-1:0]   mul_res_s;
    logic               mul_carry_s;

    logic [WIDTH-1:0]   lfsr_r;
    logic [WIDTH-1:0]   lfsr_adv_s;
    logic [WIDTH-1:0]   lfsr_n_s;
    logic [WIDTH-1:0]   seed_val_s;

    logic [SHW-1:0]     shamt_s;
    logic [WIDTH:0]     wide_s;
    logic signed [WIDTH:0] sra_s;
    logic [WIDTH-1:0]   alu_res_s;
    logic               alu_carry_s;

    logic [WIDTH-1:0]   result_r;
    logic               zero_r;
    logic               carry_r;
    logic               out_valid_r;

    assign accept_s  = in_valid && in_ready_s;
    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign zero      = zero_r;
    assign carry     = carry_r;
    assign shamt_s   = b[SHW-1:0];

    // Request acceptance: open in IDLE, or in OUT once the consumer takes the result.
    always_comb begin
        in_ready_s = 1'b0;
        if (rst) begin
            in_ready_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: in_ready_s = 1'b1;
                ST_OUT:  in_ready_s = out_ready;
                default: in_ready_s = 1'b0;
            endcase
        end
    end

    // LFSR next state: Galois advance, replaced by the seed load on a SEED accept.
    always_comb begin
        lfsr_adv_s = lfsr_r[0] ? ((lfsr_r >> 1'b1) ^ LFSR_TAPS) : (lfsr_r >> 1'b1);
        seed_val_s = (a == {WIDTH{1'b0}}) ? LFSR_SEED : a;
        if (accept_s && (op == OP_SEED)) begin
            lfsr_n_s = seed_val_s;
        end else if (lfsr_adv_s == {WIDTH{1'b0}}) begin
            // Lock-up guard: an all-zero state would never leave zero.
            lfsr_n_s = LFSR_SEED;
        end else begin
            lfsr_n_s = lfsr_adv_s;
        end
    end

    // LFSR register: free-running every non-reset cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_r <= LFSR_SEED;
        end else begin
            lfsr_r <= lfsr_n_s;
        end
    end

    // Single-cycle datapath; shifts carry the last bit out via a one-bit extension.
    always_comb begin
        alu_res_s   = {WIDTH{1'b0}};
        alu_carry_s = 1'b0;
        wide_s      = {(WIDTH+1){1'b0}};
        sra_s       = {(WIDTH+1){1'b0}};
        case (op)
            OP_ADD: begin
                wide_s      = {1'b0, a} + {1'b0, b};
                alu_res_s   = wide_s[WIDTH-1:0];
                alu_carry_s = wide_s[WIDTH];
            end
            OP_SUB: begin
                alu_res_s   = a - b;
                alu_carry_s = (a < b);
            end
            OP_AND: alu_res_s = a & b;
            OP_OR:  alu_res_s = a | b;
            OP_XOR: alu_res_s = a ^ b;
            OP_CLAMP: begin
                if (a > b) begin
                    alu_res_s   = b;
                    alu_carry_s = 1'b1;
                end else begin
                    alu_res_s   = a;
                    alu_carry_s = 1'b0;
                end
            end
            OP_ADDI: begin
                wide_s      = {1'b0, a} + {1'b0, imm};
                alu_res_s   = wide_s[WIDTH-1:0];
                alu_carry_s = wide_s[WIDTH];
            end
            OP_RNG:  alu_res_s = lfsr_n_s;
            OP_SEED: alu_res_s = lfsr_n_s;
            OP_SHL: begin
                wide_s      = {1'b0, a} << shamt_s;
                alu_res_s   = wide_s[WIDTH-1:0];
                alu_carry_s = wide_s[WIDTH];
            end
            OP_SHR: begin
                wide_s      = {a, 1'b0} >> shamt_s;
                alu_res_s   = wide_s[WIDTH:1];
                alu_carry_s = wide_s[0];
            end
            OP_SRA: begin
                sra_s       = $signed({a, 1'b0}) >>> shamt_s;
                alu_res_s   = sra_s[WIDTH:1];
                alu_carry_s = sra_s[0];
            end
            OP_MUL: begin
                // Reached only when the multiplier is not built: illegal-op result.
                alu_res_s   = {WIDTH{1'b0}};
                alu_carry_s = 1'b0;
            end
            default: begin
                alu_res_s   = {WIDTH{1'b0}};
                alu_carry_s = 1'b0;
            end
        endcase
    end

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] prod_r;
    logic [2*WIDTH-1:0] prod_n_s;
    logic [WIDTH-1:0]   mcand_r;
    logic [SHW-1:0]     cnt_r;
    logic [WIDTH:0]     psum_s;

    assign is_mul_s    = (op == OP_MUL);
    assign mul_done_s  = (state_r == ST_BUSY) && (cnt_r == SHW'(WIDTH - 1));
    assign mul_res_s   = prod_n_s[WIDTH-1:0];
    assign mul_carry_s = |prod_n_s[2*WIDTH-1:WIDTH];

    // One shift-add step: add multiplicand to the high half when the low bit is set.
    always_comb begin
        psum_s   = {1'b0, prod_r[2*WIDTH-1:WIDTH]}
                 + (prod_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
        prod_n_s = {psum_s, prod_r[WIDTH-1:1]};
    end

    // Multiplier state: load operands on accept, step once per BUSY cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_r  <= {(2*WIDTH){1'b0}};
            mcand_r <= {WIDTH{1'b0}};
            cnt_r   <= {SHW{1'b0}};
        end else if (accept_s && is_mul_s) begin
            prod_r  <= {{WIDTH{1'b0}}, b};
            mcand_r <= a;
            cnt_r   <= {SHW{1'b0}};
        end else if (state_r == ST_BUSY) begin
            prod_r  <= prod_n_s;
            cnt_r   <= cnt_r + 1'b1;
        end else begin
            prod_r  <= prod_r;
            cnt_r   <= cnt_r;
        end
    end
`else
    assign is_mul_s    = 1'b0;
    assign mul_done_s  = 1'b0;
    assign mul_res_s   = {WIDTH{1'b0}};
    assign mul_carry_s = 1'b0;
`endif

    // Next-state logic for IDLE / BUSY / OUT handshake sequencing.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (is_mul_s) begin
                        state_n_s = ST_BUSY;
                    end else begin
                        state_n_s = ST_OUT;
                    end
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
`ifdef ALU_MUL_EN
                if (mul_done_s) begin
                    state_n_s = ST_OUT;
                end else begin
                    state_n_s = ST_BUSY;
                end
`else
                state_n_s = ST_IDLE;
`endif
            end
            ST_OUT: begin
                if (out_ready) begin
                    if (accept_s) begin
                        if (is_mul_s) begin
                            state_n_s = ST_BUSY;
                        end else begin
                            state_n_s = ST_OUT;
                        end
                    end else begin
                        state_n_s = ST_IDLE;
                    end
                end else begin
                    state_n_s = ST_OUT;
                end
            end
            default: state_n_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Output registers: update only when an operation completes, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            zero_r      <= 1'b0;
            carry_r     <= 1'b0;
        end else begin
            out_valid_r <= (state_n_s == ST_OUT);
            if (accept_s && !is_mul_s) begin
                result_r <= alu_res_s;
                zero_r   <= (alu_res_s == {WIDTH{1'b0}});
                carry_r  <= alu_carry_s;
            end else if (mul_done_s) begin
                result_r <= mul_res_s;
                zero_r   <= (mul_res_s == {WIDTH{1'b0}});
                carry_r  <= mul_carry_s;
            end else begin
                result_r <= result_r;
                zero_r   <= zero_r;
                carry_r  <= carry_r;
            end
        end
    end

endmodule
